// File: rtl/writeback_unit_if.sv
// Producer-side bundle for writeback_unit: ALU and long-latency result channels,
// issue channel, hazard query, register-file write port and scoreboard.
//   slave  : seen by writeback_unit (accepts results, drives write port)
//   master : seen by the producers / register file side
interface writeback_unit_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ADDR  = 5
);
    localparam int unsigned NREG = 2 ** ADDR;

    logic              A_Valid;
    logic              A_Ready;
    logic [ADDR-1:0]   A_Dest;
    logic [WIDTH-1:0]  A_Data;

    logic              L_Valid;
    logic              L_Ready;
    logic [ADDR-1:0]   L_Dest;
    logic [WIDTH-1:0]  L_Data;

    logic              Issue_Valid;
    logic              Issue_Ready;
    logic [ADDR-1:0]   Issue_Dest;

    logic [ADDR-1:0]   Read_Register1;
    logic [ADDR-1:0]   Read_Register2;
    logic              Busy1;
    logic              Busy2;

    logic              Reg_Write;
    logic [ADDR-1:0]   Write_Register;
    logic [WIDTH-1:0]  Write_Data;
    logic [NREG-1:0]   Pending;

    modport slave (
        input  A_Valid, A_Dest, A_Data,
        input  L_Valid, L_Dest, L_Data,
        input  Issue_Valid, Issue_Dest,
        input  Read_Register1, Read_Register2,
        output A_Ready, L_Ready, Issue_Ready,
        output Busy1, Busy2,
        output Reg_Write, Write_Register, Write_Data, Pending
    );

    modport master (
        output A_Valid, A_Dest, A_Data,
        output L_Valid, L_Dest, L_Data,
        output Issue_Valid, Issue_Dest,
        output Read_Register1, Read_Register2,
        input  A_Ready, L_Ready, Issue_Ready,
        input  Busy1, Busy2,
        input  Reg_Write, Write_Register, Write_Data, Pending
    );
endinterface

// File: rtl/writeback_unit.sv
// Register-file write-side master. Merges single-cycle ALU results (priority)
// with long-latency results buffered in a DEPTH-entry FIFO onto one write port,
// and tracks registers still owed a long-latency result in a pending scoreboard.
// Ports:
//   Clock   : rising-edge clock shared with the register file
//   Reset_n : asynchronous active-low reset
//   bus     : writeback_unit_if.slave (result/issue handshakes, hazard query,
//             Reg_Write/Write_Register/Write_Data write port, Pending)
module writeback_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ADDR  = 5,
    parameter int unsigned DEPTH = 4
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    writeback_unit_if.slave       bus
);
    localparam int unsigned NREG  = 2 ** ADDR;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR-1:0]  fifo_dest [DEPTH];
    logic [WIDTH-1:0] fifo_data [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             reg_write_q;
    logic [ADDR-1:0]  write_register_q;
    logic [WIDTH-1:0] write_data_q;
    logic             src_l_q;
    logic [NREG-1:0]  pending_q;
    logic [NREG-1:0]  pending_nxt;

    logic l_ready;
    logic a_ready;
    logic issue_ready;
    logic a_fire;
    logic l_fire;
    logic issue_fire;
    logic pop;

    // Handshake readiness: FIFO space gates both producers; WAW guard on the ALU
    always_comb begin
        l_ready     = (count < CNT_W'(DEPTH));
        a_ready     = l_ready && ((bus.A_Dest == '0) || !pending_q[bus.A_Dest]);
        issue_ready = !pending_q[bus.Issue_Dest];
        a_fire      = bus.A_Valid && a_ready;
        l_fire      = bus.L_Valid && l_ready;
        issue_fire  = bus.Issue_Valid && issue_ready;
        pop         = !a_fire && (count != '0);
    end

    // Scoreboard: clear on the commit edge of an L-sourced write, set on issue
    always_comb begin
        pending_nxt = pending_q;
        if (reg_write_q && src_l_q) begin
            pending_nxt[write_register_q] = 1'b0;
        end
        if (issue_fire && (bus.Issue_Dest != '0)) begin
            pending_nxt[bus.Issue_Dest] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // FIFO storage needs no reset; validity is carried by count
    always_ff @(posedge Clock) begin
        if (l_fire) begin
            fifo_dest[wr_ptr] <= bus.L_Dest;
            fifo_data[wr_ptr] <= bus.L_Data;
        end
    end

    // FIFO pointers/count, write-port arbitration and scoreboard state
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            reg_write_q      <= 1'b0;
            write_register_q <= '0;
            write_data_q     <= '0;
            src_l_q          <= 1'b0;
            pending_q        <= '0;
        end else begin
            if (l_fire) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({l_fire, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            // Register 0 slots are consumed but never enable the write
            if (a_fire) begin
                reg_write_q      <= (bus.A_Dest != '0);
                write_register_q <= bus.A_Dest;
                write_data_q     <= bus.A_Data;
                src_l_q          <= 1'b0;
            end else if (pop) begin
                reg_write_q      <= (fifo_dest[rd_ptr] != '0);
                write_register_q <= fifo_dest[rd_ptr];
                write_data_q     <= fifo_data[rd_ptr];
                src_l_q          <= 1'b1;
            end else begin
                reg_write_q      <= 1'b0;
                src_l_q          <= 1'b0;
            end

            pending_q <= pending_nxt;
        end
    end

    assign bus.L_Ready        = l_ready;
    assign bus.A_Ready        = a_ready;
    assign bus.Issue_Ready    = issue_ready;
    assign bus.Busy1          = pending_q[bus.Read_Register1];
    assign bus.Busy2          = pending_q[bus.Read_Register2];
    assign bus.Reg_Write      = reg_write_q;
    assign bus.Write_Register = write_register_q;
    assign bus.Write_Data     = write_data_q;
    assign bus.Pending        = pending_q;
endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit.
module tb_writeback_unit;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    writeback_unit_if #(.WIDTH(32), .ADDR(5)) bus ();

    writeback_unit #(.WIDTH(32), .ADDR(5), .DEPTH(4)) dut (
        .Clock   (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.A_Valid        = 1'b0;
        bus.A_Dest         = '0;
        bus.A_Data         = '0;
        bus.L_Valid        = 1'b0;
        bus.L_Dest         = '0;
        bus.L_Data         = '0;
        bus.Issue_Valid    = 1'b0;
        bus.Issue_Dest     = '0;
        bus.Read_Register1 = '0;
        bus.Read_Register2 = '0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset while a write is in the output register
        bus.A_Valid = 1'b1; bus.A_Dest = 5'd3; bus.A_Data = 32'h55;
        tick();
        bus.A_Valid = 1'b0;
        chk("pre_rst_rw", 32'(bus.Reg_Write), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rw", 32'(bus.Reg_Write), 32'd0);
        chk("rst_wr", 32'(bus.Write_Register), 32'd0);
        chk("rst_wd", bus.Write_Data, 32'd0);
        chk("rst_pend", bus.Pending, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_lready", 32'(bus.L_Ready), 32'd1);
        chk("rst_aready", 32'(bus.A_Ready), 32'd1);
        tick();
        chk("rst_rw_idle", 32'(bus.Reg_Write), 32'd0);

        // Single ALU write
        bus.A_Valid = 1'b1; bus.A_Dest = 5'd5; bus.A_Data = 32'hDEADBEEF;
        #1 chk("alu_ready", 32'(bus.A_Ready), 32'd1);
        tick();
        bus.A_Valid = 1'b0;
        chk("alu_rw", 32'(bus.Reg_Write), 32'd1);
        chk("alu_wr", 32'(bus.Write_Register), 32'd5);
        chk("alu_wd", bus.Write_Data, 32'hDEADBEEF);
        tick();
        chk("alu_rw_off", 32'(bus.Reg_Write), 32'd0);
        chk("alu_wr_hold", 32'(bus.Write_Register), 32'd5);
        chk("alu_wd_hold", bus.Write_Data, 32'hDEADBEEF);

        // Issue to 9, WAW block, long-latency completion and scoreboard clear
        bus.Issue_Valid = 1'b1; bus.Issue_Dest = 5'd9;
        #1 chk("iss_ready", 32'(bus.Issue_Ready), 32'd1);
        tick();
        bus.Issue_Valid = 1'b0;
        bus.Read_Register1 = 5'd9; bus.Read_Register2 = 5'd0;
        bus.A_Dest = 5'd9;
        #1;
        chk("iss_pend", bus.Pending, 32'h0000_0200);
        chk("waw_aready", 32'(bus.A_Ready), 32'd0);
        chk("iss_again", 32'(bus.Issue_Ready), 32'd0);
        chk("busy1_set", 32'(bus.Busy1), 32'd1);
        chk("busy2_r0", 32'(bus.Busy2), 32'd0);
        bus.L_Valid = 1'b1; bus.L_Dest = 5'd9; bus.L_Data = 32'h1234;
        #1 chk("l9_ready", 32'(bus.L_Ready), 32'd1);
        tick();
        bus.L_Valid = 1'b0;
        chk("l9_push_rw", 32'(bus.Reg_Write), 32'd0);
        chk("l9_push_busy", 32'(bus.Busy1), 32'd1);
        tick();
        chk("l9_rw", 32'(bus.Reg_Write), 32'd1);
        chk("l9_wr", 32'(bus.Write_Register), 32'd9);
        chk("l9_wd", bus.Write_Data, 32'h1234);
        chk("l9_busy_hold", 32'(bus.Busy1), 32'd1);
        chk("l9_aready_hold", 32'(bus.A_Ready), 32'd0);
        tick();
        chk("l9_busy_clr", 32'(bus.Busy1), 32'd0);
        chk("l9_aready_up", 32'(bus.A_Ready), 32'd1);
        chk("l9_pend_clr", bus.Pending, 32'd0);
        chk("l9_rw_off", 32'(bus.Reg_Write), 32'd0);

        // Fill FIFO with regs 1..4 while the ALU keeps hitting reg 7
        bus.A_Valid = 1'b1; bus.A_Dest = 5'd7; bus.A_Data = 32'h70;
        bus.L_Valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.L_Dest = 5'(i);
            bus.L_Data = 32'(i * 32'h11);
            tick();
        end
        bus.L_Valid = 1'b0;
        #1;
        chk("full_lready", 32'(bus.L_Ready), 32'd0);
        chk("full_aready", 32'(bus.A_Ready), 32'd0);
        chk("full_wr7", 32'(bus.Write_Register), 32'd7);
        tick();
        chk("drain1_rw", 32'(bus.Reg_Write), 32'd1);
        chk("drain1_wr", 32'(bus.Write_Register), 32'd1);
        chk("drain1_wd", bus.Write_Data, 32'h11);
        chk("drain1_aready", 32'(bus.A_Ready), 32'd1);
        chk("drain1_lready", 32'(bus.L_Ready), 32'd1);
        tick();
        bus.A_Valid = 1'b0;
        chk("resume7_wr", 32'(bus.Write_Register), 32'd7);
        chk("resume7_wd", bus.Write_Data, 32'h70);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk("drain_rw", 32'(bus.Reg_Write), 32'd1);
            chk("drain_wr", 32'(bus.Write_Register), 32'(i));
            chk("drain_wd", bus.Write_Data, 32'(i * 32'h11));
        end
        tick();
        chk("drain_idle", 32'(bus.Reg_Write), 32'd0);

        // Register 0 results and issue
        bus.A_Valid = 1'b1; bus.A_Dest = 5'd0; bus.A_Data = 32'hAA;
        #1 chk("r0_aready", 32'(bus.A_Ready), 32'd1);
        tick();
        bus.A_Valid = 1'b0;
        chk("r0_a_rw", 32'(bus.Reg_Write), 32'd0);
        chk("r0_a_wd", bus.Write_Data, 32'hAA);
        bus.L_Valid = 1'b1; bus.L_Dest = 5'd0; bus.L_Data = 32'hBB;
        tick();
        bus.L_Valid = 1'b0;
        chk("r0_push_rw", 32'(bus.Reg_Write), 32'd0);
        tick();
        chk("r0_pop_rw", 32'(bus.Reg_Write), 32'd0);
        chk("r0_pop_wr", 32'(bus.Write_Register), 32'd0);
        chk("r0_pop_wd", bus.Write_Data, 32'hBB);
        bus.Issue_Valid = 1'b1; bus.Issue_Dest = 5'd0;
        #1 chk("r0_iss_ready", 32'(bus.Issue_Ready), 32'd1);
        tick();
        bus.Issue_Valid = 1'b0;
        chk("r0_iss_pend", bus.Pending, 32'd0);

        // Three entries held in the FIFO by ALU priority, then async reset
        bus.A_Valid = 1'b1; bus.A_Dest = 5'd7; bus.A_Data = 32'h77;
        bus.L_Valid = 1'b1;
        for (int i = 10; i <= 12; i++) begin
            bus.L_Dest = 5'(i);
            bus.L_Data = 32'(i);
            tick();
        end
        bus.A_Valid = 1'b0;
        bus.L_Valid = 1'b0;
        chk("mid_rw", 32'(bus.Reg_Write), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rw", 32'(bus.Reg_Write), 32'd0);
        chk("mid_rst_wr", 32'(bus.Write_Register), 32'd0);
        chk("mid_rst_wd", bus.Write_Data, 32'd0);
        chk("mid_rst_lready", 32'(bus.L_Ready), 32'd1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_rw", 32'(bus.Reg_Write), 32'd0);
        end
        chk("post_rst_pend", bus.Pending, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Write-side master for the 32x32 register file: produces the file's write-port signals (Reg_Write, Write_Register, Write_Data).
- Merges results from two producers onto the single write port:
  - ALU: single-cycle, has priority.
  - Long-latency unit (loads / multi-cycle ops): buffered in a DEPTH-entry FIFO.
- Keeps a 32-bit pending scoreboard so the read side can stall on registers still awaiting a long-latency result.

Parameters:
- WIDTH, 32, data width of a register.
- ADDR, 5, register index width; register count is 2**ADDR.
- DEPTH, 4, long-latency result FIFO entries; power of two, at least 2.

Ports:
- Clock  in  1  rising-edge clock, shared with the register file.
- Reset_n  in  1  asynchronous active-low reset.
- A_Valid  in  1  ALU result valid.
- A_Ready  out  1  ALU result accepted this cycle.
- A_Dest  in  ADDR  ALU destination register.
- A_Data  in  WIDTH  ALU result.
- L_Valid  in  1  long-latency result valid.
- L_Ready  out  1  FIFO can accept a result.
- L_Dest  in  ADDR  long-latency destination register.
- L_Data  in  WIDTH  long-latency result.
- Issue_Valid  in  1  long-latency op issued; mark its destination pending.
- Issue_Ready  out  1  issue accepted.
- Issue_Dest  in  ADDR  destination of the issued op.
- Read_Register1  in  ADDR  read-side index for hazard query.
- Read_Register2  in  ADDR  read-side index for hazard query.
- Busy1  out  1  Read_Register1 is pending.
- Busy2  out  1  Read_Register2 is pending.
- Reg_Write  out  1  write enable to the register file.
- Write_Register  out  ADDR  write index to the register file.
- Write_Data  out  WIDTH  write data to the register file.
- Pending  out  2**ADDR  scoreboard, one bit per register.

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - FIFO emptied; Pending=0.
  - Reg_Write=0, Write_Register=0, Write_Data=0; internal source flag cleared.
  - Any in-flight result is discarded. Reset mid-operation loses FIFO contents, and no write is issued after reset release until new input arrives.
- Handshakes: a transfer occurs on a rising edge where Valid and Ready are both 1.
  - Ready signals are combinational from registered state and the current Dest inputs.
  - Ready never depends on Valid of the same port.
- L_Ready = (FIFO count < DEPTH).
  - No pass-through when full: a simultaneous pop does not raise L_Ready in the same cycle.
- A_Ready = (count < DEPTH) and not Pending[A_Dest].
  - When the FIFO is full, the FIFO has priority so the long-latency path cannot starve.
  - WAW guard: the ALU may not write a register still owed a long-latency result.
  - A_Dest=0 ignores the Pending check.
- Issue_Ready = not Pending[Issue_Dest]. Issue_Dest=0 is accepted but never sets a bit.
- Write-port arbitration, decided every cycle:
  - If an A transfer occurs, the output register loads A (source=ALU).
  - Else if the FIFO is non-empty, pop the head into the output register (source=L).
  - Else Reg_Write=0 next cycle; Write_Register and Write_Data hold their previous values.
- Latency:
  - Result accepted at edge N -> Reg_Write=1 with its index and data during cycle N+1.
  - The register file commits it at edge N+1.
  - An L result pushed at edge N into an empty FIFO with no A transfer pops at edge N+1 and is written during cycle N+2.
- Register 0:
  - A result with Dest=0 is accepted and consumed (popped) normally.
  - Reg_Write stays 0 for that slot; Write_Register and Write_Data still update.
  - Pending[0] and Busy for index 0 are always 0.
- Scoreboard:
  - Bit set on an accepted Issue.
  - Bit cleared on the edge where Reg_Write=1 and source=L for that Write_Register, i.e. the register file's commit edge. Busy therefore covers the cycle where the write is still in the output register.
  - A long-latency result for a non-pending register is written normally; clearing an already-clear bit is a no-op.
- Busy1/Busy2 = Pending[Read_Register1/2]: combinational, no reset dependence beyond Pending.
- FIFO:
  - Circular buffer with ADDR-independent read/write pointers that wrap at DEPTH.
  - Count is DEPTH+1 states wide.
  - Simultaneous push and pop keeps count unchanged.
  - Order is strictly preserved.

Test Plan:
- Reset with Reg_Write forced busy, release -> all outputs 0, Pending=0, L_Ready=1, A_Ready=1.
- A_Valid, A_Dest=5, A_Data=0xDEADBEEF at edge 1 -> cycle 2: Reg_Write=1, Write_Register=5, Write_Data=0xDEADBEEF; cycle 3: Reg_Write=0.
- Issue_Dest=9, then A_Dest=9 -> A_Ready=0, Busy1=1 when Read_Register1=9.
  - L result (9, 0x1234) pushed -> Reg_Write written during the cycle after the pop.
  - Busy1 drops to 0 exactly after that commit edge; A_Ready to 9 rises in the same cycle.
- Push 4 L results (regs 1..4) while A_Valid continuously targets reg 7:
  - L_Ready=0 after 4 pushes.
  - A_Ready=0 while count=4.
  - Writes appear in order 1,2,3,4, and the reg-7 writes resume once count<4.
- A_Dest=0 and L_Dest=0 results -> both accepted/popped, Reg_Write stays 0 throughout; Issue_Dest=0 leaves Pending=0.
- Fill FIFO with 3 entries, assert Reset_n=0 mid-cycle -> outputs 0 immediately (asynchronous). After release, no Reg_Write pulse occurs without new input.
